// File: rtl/pic_priority_core.sv
// Purpose : 8259-style interrupt priority core (IRR/ISR, mask, fixed/rotating priority, INTA handshake, EOI).
// Latency : int_out one cycle after IRR/ISR/mask change; vec_valid one cycle after the second inta pulse.
// Backpress: none; inta/eoi strobes are accepted every cycle and ACK1 waits indefinitely for the second inta.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   irq_in, imr_in           synchronised request lines and mask (1 = masked)
//   mode_ar, mode_level      automatic rotation / level-triggered capture
//   aeoi                     auto-EOI on the second inta pulse
//   inta                     acknowledge pulse, two per service cycle
//   eoi_ns, eoi_sp, eoi_lvl  non-specific / specific end-of-interrupt
//   int_out                  registered interrupt request to the CPU
//   vec_valid, vec_out       one-cycle vector strobe, VEC_BASE + serviced line
//   irr_out, isr_out         request and in-service register readback
module pic_priority_core #(
   parameter int N_IRQ    = 8,
   parameter int VEC_BASE = 0,
   parameter int VEC_W    = 8,
   localparam int IW      = $clog2(N_IRQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IRQ-1:0]  irq_in,
   input  logic [N_IRQ-1:0]  imr_in,
   input  logic              mode_ar,
   input  logic              mode_level,
   input  logic              aeoi,
   input  logic              inta,
   input  logic              eoi_ns,
   input  logic              eoi_sp,
   input  logic [IW-1:0]     eoi_lvl,
   output logic              int_out,
   output logic              vec_valid,
   output logic [VEC_W-1:0]  vec_out,
   output logic [N_IRQ-1:0]  irr_out,
   output logic [N_IRQ-1:0]  isr_out
);

   typedef enum logic {S_IDLE, S_ACK1} state_t;

   localparam logic [IW:0]      N_L  = (IW+1)'(N_IRQ);
   localparam logic [IW-1:0]    LAST = IW'(N_IRQ - 1);
   localparam logic [VEC_W-1:0] VB   = VEC_W'(VEC_BASE);

   state_t             state_q, state_d;
   logic [N_IRQ-1:0]   irr_q, irr_d;
   logic [N_IRQ-1:0]   isr_q, isr_d;
   logic [N_IRQ-1:0]   prev_q;
   logic [IW-1:0]      rot_q, rot_d;
   logic [IW-1:0]      w_q, w_d;
   logic               spur_q, spur_d;
   logic               int_q, int_d;
   logic               vld_q, vld_d;
   logic [VEC_W-1:0]   vec_q, vec_d;

   logic [N_IRQ-1:0]   pend;
   logic [N_IRQ-1:0]   irr_clr;
   logic               pend_found, isr_found;
   logic [IW-1:0]      pend_idx, isr_idx;
   logic [IW:0]        pend_rank, isr_rank;

   // Line index holding priority rank k when rank 0 sits at base.
   function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input logic [IW:0] k);
      logic [IW:0] s;
      s = {1'b0, base} + k;
      if (s >= N_L) s = s - N_L;
      return s[IW-1:0];
   endfunction

   function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] x);
      logic [IW:0] s;
      s = {1'b0, x} + (IW+1)'(1);
      if (s == N_L) s = '0;
      return s[IW-1:0];
   endfunction

   assign pend = irr_q & ~imr_in;

   // Scan from the current rotation base; the first hit is the highest priority.
   // An empty ISR keeps rank N_L so any pending line outranks it.
   always_comb begin
      pend_found = 1'b0;
      pend_idx   = '0;
      pend_rank  = N_L;
      isr_found  = 1'b0;
      isr_idx    = '0;
      isr_rank   = N_L;
      for (int k = 0; k < N_IRQ; k++) begin
         if (!pend_found && pend[slot(rot_q, k[IW:0])]) begin
            pend_found = 1'b1;
            pend_idx   = slot(rot_q, k[IW:0]);
            pend_rank  = k[IW:0];
         end
         if (!isr_found && isr_q[slot(rot_q, k[IW:0])]) begin
            isr_found = 1'b1;
            isr_idx   = slot(rot_q, k[IW:0]);
            isr_rank  = k[IW:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      isr_d   = isr_q;
      rot_d   = rot_q;
      w_d     = w_q;
      spur_d  = spur_q;
      vld_d   = 1'b0;
      vec_d   = vec_q;
      irr_clr = '0;
      int_d   = pend_found && (pend_rank < isr_rank);

      // EOI looks at the ISR as it stood before any same-cycle acknowledge.
      if (eoi_sp) begin
         if (({1'b0, eoi_lvl} < N_L) && isr_q[eoi_lvl]) begin
            isr_d[eoi_lvl] = 1'b0;
            if (mode_ar) rot_d = inc_mod(eoi_lvl);
         end
      end else if (eoi_ns && isr_found) begin
         isr_d[isr_idx] = 1'b0;
         if (mode_ar) rot_d = inc_mod(isr_idx);
      end

      case (state_q)
         S_IDLE: begin
            if (inta) begin
               state_d = S_ACK1;
               int_d   = 1'b0;
               if (pend_found) begin
                  w_d               = pend_idx;
                  spur_d            = 1'b0;
                  isr_d[pend_idx]   = 1'b1;
                  irr_clr[pend_idx] = 1'b1;
               end else begin
                  // Nothing pending: deliver the lowest fixed line, touch no state.
                  w_d    = LAST;
                  spur_d = 1'b1;
               end
            end
         end
         S_ACK1: begin
            if (inta) begin
               state_d = S_IDLE;
               vld_d   = 1'b1;
               vec_d   = VB + VEC_W'(w_q);
               if (aeoi && !spur_q) begin
                  isr_d[w_q] = 1'b0;
                  if (mode_ar) rot_d = inc_mod(w_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!mode_ar) rot_d = '0;

      // Level mode follows the pins; in edge mode a new rising edge beats the acknowledge clear.
      irr_d = mode_level ? irq_in : ((irr_q & ~irr_clr) | (irq_in & ~prev_q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         irr_q   <= '0;
         isr_q   <= '0;
         prev_q  <= '0;
         rot_q   <= '0;
         w_q     <= '0;
         spur_q  <= 1'b0;
         int_q   <= 1'b0;
         vld_q   <= 1'b0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         irr_q   <= irr_d;
         isr_q   <= isr_d;
         prev_q  <= irq_in;
         rot_q   <= rot_d;
         w_q     <= w_d;
         spur_q  <= spur_d;
         int_q   <= int_d;
         vld_q   <= vld_d;
         vec_q   <= vec_d;
      end
   end

   assign int_out   = int_q;
   assign vec_valid = vld_q;
   assign vec_out   = vec_q;
   assign irr_out   = irr_q;
   assign isr_out   = isr_q;

endmodule
